spi_master_n: RTL and testbench
===============================

# spi_master_n

Parametrised SPI master: the successor to the fixed 8-bit, four-speed transceiver. Word width, chip-select count and SCLK divider width are parameters. The divider is a run-time value instead of a fixed speed table. Chip-select generation with setup/hold spacing and multi-word burst hold are handled in the block. It sits between a bus-facing register block and external SPI devices (SD card, flash, ADC).

## Interface
- DATA_W, 8, bits per transfer, 2..32
- NCS, 4, chip-select lines, 1..16
- DIV_W, 16, width of half-period divider
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- start  in  1  request transfer; sampled only in IDLE
- div  in  DIV_W  SCLK half-period = div+1 clk_i cycles
- cpol, cpha  in  1 each  SPI mode
- cs_sel  in  $clog2(NCS) (min 1)  target chip select
- hold  in  1  keep selected cs_n low after transfer
- tx  in  DATA_W  word to send
- rx  out  DATA_W  received word
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- miso  in  1; mosi  out  1; sclk  out  1
- cs_n  out  NCS  active-low chip selects

## Operation
- States: IDLE, SETUP, LEAD, TRAIL, CSHOLD. A half-period tick is generated from a counter 0..div. The counter clears on entry to SETUP and on every tick.
- IDLE:
  - sclk is driven to the captured cpol.
  - start=1 captures tx, div, cpol, cpha, cs_sel and hold. Inputs are ignored until the next IDLE.
  - cs_n[cs_sel] goes low and the state moves to SETUP.
- SETUP: lasts one half-period. For cpha=0, mosi already presents the MSB.
- LEAD: sclk toggles on the tick.
  - cpha=0: sample miso.
  - cpha=1: shift the next bit out.
- TRAIL: sclk toggles on the tick.
  - cpha=0: shift.
  - cpha=1: sample.
  - Bit counter decrements from DATA_W-1. At 0, go to CSHOLD; otherwise go to LEAD.
- CSHOLD: lasts one half-period, then go to IDLE with done=1 and rx updated.
  - hold=0: cs_n returns to all-ones on that same cycle.
  - hold=1: the selected cs_n stays low.
- While held, the next start keeps the line low; a different cs_sel switches lines in the same cycle. Held CS releases on the first IDLE cycle where the hold input is 0 and no start is present.
- start while busy=1 is ignored and causes no error.
- cpha=1: the first mosi bit appears at the first LEAD tick. The final sample is taken at the last TRAIL tick.

## Timing
- Reset values: state IDLE, cs_n all ones, sclk 0, mosi 0, rx 0, busy 0, done 0, counters 0.
- Reset mid-transfer: all outputs take their reset values asynchronously. rx is not updated.
- Handshake timing:
  - start seen at cycle T; busy=1 and cs_n low from T+1.
  - done=1 exactly at T+1+(div+1)(2·DATA_W+2).
  - busy drops in the same cycle that done rises.
- rx is stable from the done cycle until the next done.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- div=0 gives sclk = clk_i/2. div all-ones gives a half-period of 2^DIV_W cycles; the counter must not overflow.
- All outputs are registered.

## Configuration
- SPI_LSB_FIRST_EN defined:
  - Adds input lsb_first (1 bit), captured at start.
  - When 1, bit 0 is shifted out first and received bits fill from the MSB end, so rx matches the device's bit order.
- SPI_LSB_FIRST_EN undefined: the port is absent and transfers are MSB-first only.

## Structure
- Package spi_pkg holds:
  - spi_state_t enum (IDLE, SETUP, LEAD, TRAIL, CSHOLD).
  - spi_mode_t packed struct {cpol, cpha}.
  - Default localparams for DATA_W, NCS, DIV_W.
- Sub-module spi_clkgen: DIV_W counter with enable, clear and div inputs, and a one-cycle tick output. The FSM, shift register and CS logic stay in spi_master_n.

## Test plan
- Mode 0, DATA_W=8, div=1, tx=0xA5, miso loopback to mosi:
  - rx=0xA5.
  - done at T+1+2·18=T+37.
  - 8 rising sclk edges; cs_n[0] low for the whole window.
- Mode 3, DATA_W=16, div=0, tx=0x1234, miso driven by a model returning 0xBEEF → rx=0xBEEF; sclk idles high before and after.
- hold=1 for two back-to-back words on cs_sel=2 → cs_n[2] is continuously low across both, then rises once hold=0 in IDLE. Other cs_n lines stay high.
- start pulsed mid-transfer and rst_i asserted mid-word:
  - The extra start is ignored.
  - Reset forces cs_n=all ones, busy=0 and rx unchanged in the same cycle.
- div=0xFFFF, DATA_W=2 → half-period of 65536 cycles and no counter wrap; done at T+1+65536·6.
- SPI_LSB_FIRST_EN, lsb_first=1, tx=0x01 → the first mosi bit is 1; loopback gives rx=0x01.

Source files
------------

// File: rtl/spi_master_n_pkg.sv
// Shared types and defaults for the parametrised SPI master (spi_master_n).
// Optional LSB-first support is enabled with the SPI_LSB_FIRST_EN macro.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      LEAD   = 3'd2,
      TRAIL  = 3'd3,
      CSHOLD = 3'd4
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam int SPI_DATA_W_DEF = 8;
   localparam int SPI_NCS_DEF    = 4;
   localparam int SPI_DIV_W_DEF  = 16;

   // A single chip select still needs a 1-bit select field.
   function automatic int cs_width(input int ncs);
      return (ncs > 1) ? $clog2(ncs) : 1;
   endfunction

endpackage

// File: rtl/spi_master_n_if.sv
// Register-side request/response bundle of spi_master_n.
// lsb_first exists only when SPI_LSB_FIRST_EN is defined.
interface spi_master_n_if
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W_DEF,
   parameter int NCS    = SPI_NCS_DEF,
   parameter int DIV_W  = SPI_DIV_W_DEF
);
   localparam int CS_W = cs_width(NCS);

   // Handshake: start is a request taken only while busy=0 (it may also be
   // raised in the done cycle); taking it raises busy the next cycle. The
   // result is flagged by a one-cycle done pulse, with rx valid from then on.
   logic              start;
   logic [DIV_W-1:0]  div;
   logic              cpol;
   logic              cpha;
   logic [CS_W-1:0]   cs_sel;
   logic              hold;
   logic [DATA_W-1:0] tx;
   logic [DATA_W-1:0] rx;
   logic              busy;
   logic              done;
`ifdef SPI_LSB_FIRST_EN
   logic              lsb_first;
`endif

   modport master (
`ifdef SPI_LSB_FIRST_EN
      output lsb_first,
`endif
      output start, div, cpol, cpha, cs_sel, hold, tx,
      input  rx, busy, done
   );

   modport slave (
`ifdef SPI_LSB_FIRST_EN
      input  lsb_first,
`endif
      input  start, div, cpol, cpha, cs_sel, hold, tx,
      output rx, busy, done
   );

endinterface

// File: rtl/spi_master_n_clkgen.sv
// Half-period tick generator: counts 0..div and pulses tick on the last count.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int DIV_W = SPI_DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // The counter wraps on the tick itself, so it never passes div_i and an
   // all-ones divider cannot overflow it.
   assign tick_o = en_i && (cnt_q == div_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_n.sv
// Parametrised SPI master: FSM, shift registers and chip-select control.
// Define SPI_LSB_FIRST_EN to add the per-transfer lsb_first option.
module spi_master_n
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W_DEF,
   parameter int NCS    = SPI_NCS_DEF,
   parameter int DIV_W  = SPI_DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   spi_master_n_if.slave    bus,
   input  logic             miso_i,
   output logic             mosi_o,
   output logic             sclk_o,
   output logic [NCS-1:0]   cs_n_o,
   output spi_state_t       state_o
);

   localparam int CS_W = cs_width(NCS);
   localparam int BW   = $clog2(DATA_W);

   spi_state_t        state_q, state_d;
   spi_mode_t         mode_q, mode_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              hold_q, hold_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rxs_q, rxs_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [NCS-1:0]    cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              lsb_q, lsb_in;
   logic              tick;

`ifdef SPI_LSB_FIRST_EN
   logic lsb_d;
   assign lsb_in = bus.lsb_first;
`else
   assign lsb_in = 1'b0;
   assign lsb_q  = 1'b0;
`endif

   function automatic logic emit_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   // LSB-first words fill from the top so the first received bit lands in bit 0.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic lsb,
                                                  input logic b);
      return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
   endfunction

   function automatic logic [NCS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NCS-1:0] r;
      r = '1;
      for (int i = 0; i < NCS; i++) begin
         if (sel == CS_W'(i)) r[i] = 1'b0;
      end
      return r;
   endfunction

   spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_q != IDLE),
      .clr_i  (state_q == IDLE),
      .div_i  (div_q),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      div_d   = div_q;
      hold_d  = hold_q;
      tx_d    = tx_q;
      rxs_d   = rxs_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_d   = lsb_q;
`endif
      case (state_q)
         IDLE: begin
            sclk_d = mode_q.cpol;
            if (bus.start) begin
               mode_d.cpol = bus.cpol;
               mode_d.cpha = bus.cpha;
               div_d       = bus.div;
               hold_d      = bus.hold;
`ifdef SPI_LSB_FIRST_EN
               lsb_d       = bus.lsb_first;
`endif
               sclk_d      = bus.cpol;
               cs_n_d      = cs_decode(bus.cs_sel);
               bit_d       = BW'(DATA_W - 1);
               rxs_d       = '0;
               busy_d      = 1'b1;
               state_d     = SETUP;
               // cpha=0 puts the first bit on the line for the whole SETUP phase.
               if (!bus.cpha) begin
                  mosi_d = emit_bit(bus.tx, lsb_in);
                  tx_d   = shift_out(bus.tx, lsb_in);
               end else begin
                  tx_d   = bus.tx;
               end
            end else if (!bus.hold) begin
               cs_n_d = '1;
            end
         end
         SETUP: begin
            if (tick) state_d = LEAD;
         end
         LEAD: begin
            if (tick) begin
               sclk_d  = ~sclk_q;
               state_d = TRAIL;
               if (mode_q.cpha) begin
                  mosi_d = emit_bit(tx_q, lsb_q);
                  tx_d   = shift_out(tx_q, lsb_q);
               end else begin
                  rxs_d  = shift_in(rxs_q, lsb_q, miso_i);
               end
            end
         end
         TRAIL: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (mode_q.cpha) begin
                  rxs_d  = shift_in(rxs_q, lsb_q, miso_i);
               end else begin
                  mosi_d = emit_bit(tx_q, lsb_q);
                  tx_d   = shift_out(tx_q, lsb_q);
               end
               if (bit_q == '0) begin
                  state_d = CSHOLD;
               end else begin
                  bit_d   = bit_q - 1'b1;
                  state_d = LEAD;
               end
            end
         end
         CSHOLD: begin
            if (tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rx_d    = rxs_q;
               if (!hold_q) cs_n_d = '1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mode_q  <= '0;
         div_q   <= '0;
         hold_q  <= 1'b0;
         tx_q    <= '0;
         rxs_q   <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         div_q   <= div_d;
         hold_q  <= hold_d;
         tx_q    <= tx_d;
         rxs_q   <= rxs_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef SPI_LSB_FIRST_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lsb_q <= 1'b0;
      end else begin
         lsb_q <= lsb_d;
      end
   end
`endif

   assign bus.rx   = rx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign mosi_o   = mosi_q;
   assign sclk_o   = sclk_q;
   assign cs_n_o   = cs_n_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_spi_master_n.sv
// Directed bench for spi_master_n: three instances (8-bit, 16-bit, 2-bit with
// a narrow divider); LSB-first case runs when SPI_LSB_FIRST_EN is defined.
module tb_spi_master_n;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   // Instance A: 8-bit, loopback
   spi_master_n_if #(.DATA_W(8), .NCS(4), .DIV_W(16)) ifa ();
   logic mosi_a, sclk_a;
   logic [3:0] cs_n_a;
   spi_state_t st_a;
   spi_master_n #(.DATA_W(8), .NCS(4), .DIV_W(16)) u_dut_a (
      .clk_i(clk), .rst_i(rst_i), .bus(ifa), .miso_i(mosi_a),
      .mosi_o(mosi_a), .sclk_o(sclk_a), .cs_n_o(cs_n_a), .state_o(st_a));

   // Instance B: 16-bit, device model on miso
   spi_master_n_if #(.DATA_W(16), .NCS(4), .DIV_W(16)) ifb ();
   logic mosi_b, sclk_b;
   logic miso_b = 1'b0;
   logic [15:0] dev_q = '0;
   logic [3:0] cs_n_b;
   spi_state_t st_b;
   spi_master_n #(.DATA_W(16), .NCS(4), .DIV_W(16)) u_dut_b (
      .clk_i(clk), .rst_i(rst_i), .bus(ifb), .miso_i(miso_b),
      .mosi_o(mosi_b), .sclk_o(sclk_b), .cs_n_o(cs_n_b), .state_o(st_b));

   // Mode-3 device: shifts a new bit out on each falling (leading) edge
   always @(sclk_b) begin
      if (!cs_n_b[0] && !sclk_b) begin
         miso_b = dev_q[15];
         dev_q  = {dev_q[14:0], 1'b0};
      end
   end

   // Instance C: 2-bit, 10-bit divider, loopback
   spi_master_n_if #(.DATA_W(2), .NCS(1), .DIV_W(10)) ifc ();
   logic mosi_c, sclk_c;
   logic [0:0] cs_n_c;
   spi_state_t st_c;
   spi_master_n #(.DATA_W(2), .NCS(1), .DIV_W(10)) u_dut_c (
      .clk_i(clk), .rst_i(rst_i), .bus(ifc), .miso_i(mosi_c),
      .mosi_o(mosi_c), .sclk_o(sclk_c), .cs_n_o(cs_n_c), .state_o(st_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a transfer on A in the current cycle and returns in the done cycle.
   task automatic xfer_a(input string tag, input logic [7:0] tx, input logic [15:0] dv,
                         input logic cpol, input logic cpha, input logic [1:0] sel,
                         input logic hold, input int poke, output int k,
                         output int rises, output logic cs_ok);
      logic prev;
      logic [3:0] mask;
      logic [31:0] e;
      mask = 4'b0001 << sel;
      ifa.tx = tx; ifa.div = dv; ifa.cpol = cpol; ifa.cpha = cpha;
      ifa.cs_sel = sel; ifa.hold = hold; ifa.start = 1'b1;
      exp_q.push_back({24'h0, tx});
      tick();
      ifa.start = 1'b0;
      k = 1; rises = 0; cs_ok = 1'b1; prev = sclk_a;
      while (!ifa.done && k < 2000) begin
         if (cs_n_a[sel] !== 1'b0 || (cs_n_a | mask) !== 4'hF) cs_ok = 1'b0;
         if (poke > 0 && k == poke) begin
            ifa.start = 1'b1; ifa.tx = ~tx; ifa.cs_sel = sel + 2'd1;
         end
         if (poke > 0 && k == poke + 1) begin
            ifa.start = 1'b0; ifa.tx = tx; ifa.cs_sel = sel;
         end
         tick();
         k++;
         if (sclk_a && !prev) rises++;
         prev = sclk_a;
      end
      chk({tag, "_done"}, 32'(ifa.done), 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_rx"}, 32'(ifa.rx), e);
   endtask

   int k, rises;
   logic cs_ok;

   initial begin
      ifa.start = 0; ifa.div = 0; ifa.cpol = 0; ifa.cpha = 0; ifa.cs_sel = 0; ifa.hold = 0; ifa.tx = 0;
      ifb.start = 0; ifb.div = 0; ifb.cpol = 0; ifb.cpha = 0; ifb.cs_sel = 0; ifb.hold = 0; ifb.tx = 0;
      ifc.start = 0; ifc.div = 0; ifc.cpol = 0; ifc.cpha = 0; ifc.cs_sel = 0; ifc.hold = 0; ifc.tx = 0;
`ifdef SPI_LSB_FIRST_EN
      ifa.lsb_first = 0; ifb.lsb_first = 0; ifc.lsb_first = 0;
`endif
      // Reset values
      repeat (3) tick();
      chk("rst_cs_n", 32'(cs_n_a), 32'hF);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_done", 32'(ifa.done), 32'd0);
      chk("rst_sclk", 32'(sclk_a), 32'd0);
      chk("rst_mosi", 32'(mosi_a), 32'd0);
      chk("rst_rx", 32'(ifa.rx), 32'd0);
      chk("rst_state", 32'(st_a), 32'(IDLE));
      rst_i = 1'b0;
      tick();

      // Reset in the middle of a word
      ifa.tx = 8'h3C; ifa.div = 16'd1; ifa.cs_sel = 2'd1; ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (8) tick();
      chk("midrst_busy_before", 32'(ifa.busy), 32'd1);
      chk("midrst_cs_before", 32'(cs_n_a), 32'hD);
      rst_i = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(cs_n_a), 32'hF);
      chk("midrst_busy", 32'(ifa.busy), 32'd0);
      chk("midrst_rx", 32'(ifa.rx), 32'd0);
      chk("midrst_state", 32'(st_a), 32'(IDLE));
      #2 rst_i = 1'b0;
      tick(); tick();

      // Mode 0, div=1, 0xA5 loopback on cs 0
      xfer_a("m0", 8'hA5, 16'd1, 1'b0, 1'b0, 2'd0, 1'b0, 0, k, rises, cs_ok);
      chk("m0_latency", 32'(k), 32'd37);
      chk("m0_rises", 32'(rises), 32'd8);
      chk("m0_cs_window", 32'(cs_ok), 32'd1);
      chk("m0_busy_at_done", 32'(ifa.busy), 32'd0);
      chk("m0_cs_release", 32'(cs_n_a), 32'hF);
      tick(); tick();

      // Extra start pulsed mid-transfer must be dropped
      xfer_a("ign", 8'h69, 16'd1, 1'b0, 1'b0, 2'd1, 1'b0, 10, k, rises, cs_ok);
      chk("ign_latency", 32'(k), 32'd37);
      chk("ign_cs_window", 32'(cs_ok), 32'd1);
      repeat (3) tick();
      chk("ign_busy_after", 32'(ifa.busy), 32'd0);
      chk("ign_cs_after", 32'(cs_n_a), 32'hF);
      chk("ign_rx_stable", 32'(ifa.rx), 32'h69);

      // Mode 1 and mode 2 loopback
      xfer_a("m1", 8'h5A, 16'd2, 1'b0, 1'b1, 2'd3, 1'b0, 0, k, rises, cs_ok);
      chk("m1_latency", 32'(k), 32'd55);
      chk("m1_rises", 32'(rises), 32'd8);
      chk("m1_cs_window", 32'(cs_ok), 32'd1);
      tick();
      xfer_a("m2", 8'hC3, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0, 0, k, rises, cs_ok);
      chk("m2_latency", 32'(k), 32'd19);
      chk("m2_rises", 32'(rises), 32'd8);
      tick(); tick();
      chk("m2_sclk_idle", 32'(sclk_a), 32'd1);

      // Two held words back to back on cs 2, then release
      xfer_a("hold1", 8'h3C, 16'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, k, rises, cs_ok);
      chk("hold1_latency", 32'(k), 32'd19);
      chk("hold1_cs_window", 32'(cs_ok), 32'd1);
      chk("hold1_cs_done", 32'(cs_n_a), 32'hB);
      xfer_a("hold2", 8'h96, 16'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, k, rises, cs_ok);
      chk("hold2_latency", 32'(k), 32'd19);
      chk("hold2_cs_window", 32'(cs_ok), 32'd1);
      chk("hold2_cs_done", 32'(cs_n_a), 32'hB);
      tick();
      chk("hold_still_low", 32'(cs_n_a), 32'hB);
      ifa.hold = 1'b0;
      tick();
      chk("hold_release", 32'(cs_n_a), 32'hF);

      // Mode 3, 16-bit, div=0, device answers 0xBEEF
      chk("m3_sclk_pre", 32'(sclk_b), 32'd0);
      ifb.tx = 16'h1234; ifb.div = 16'd0; ifb.cpol = 1'b1; ifb.cpha = 1'b1;
      ifb.cs_sel = 2'd0; ifb.hold = 1'b0; dev_q = 16'hBEEF; ifb.start = 1'b1;
      exp_q.push_back(32'h0000BEEF);
      tick();
      ifb.start = 1'b0;
      chk("m3_sclk_setup", 32'(sclk_b), 32'd1);
      k = 1;
      while (!ifb.done && k < 2000) begin tick(); k++; end
      chk("m3_latency", 32'(k), 32'd35);
      chk("m3_rx", 32'(ifb.rx), exp_q.pop_front());
      tick(); tick();
      chk("m3_sclk_idle", 32'(sclk_b), 32'd1);

      // All-ones divider on the narrow instance: half-period 1024 cycles
      ifc.tx = 2'b10; ifc.div = 10'h3FF; ifc.start = 1'b1;
      exp_q.push_back(32'd2);
      tick();
      ifc.start = 1'b0;
      k = 1;
      while (!ifc.done && k < 8000) begin tick(); k++; end
      chk("wide_div_latency", 32'(k), 32'd6145);
      chk("wide_div_rx", 32'(ifc.rx), exp_q.pop_front());

`ifdef SPI_LSB_FIRST_EN
      tick();
      ifa.lsb_first = 1'b1; ifa.tx = 8'h01; ifa.div = 16'd1; ifa.cpol = 1'b0; ifa.cpha = 1'b0;
      ifa.cs_sel = 2'd0; ifa.hold = 1'b0; ifa.start = 1'b1;
      exp_q.push_back(32'h01);
      tick();
      ifa.start = 1'b0;
      chk("lsb_first_bit", 32'(mosi_a), 32'd1);
      k = 1;
      while (!ifa.done && k < 2000) begin tick(); k++; end
      chk("lsb_latency", 32'(k), 32'd37);
      chk("lsb_rx", 32'(ifa.rx), exp_q.pop_front());
      ifa.lsb_first = 1'b0;
`endif

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
